// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : cpu_pkg                                                     |
// | Description : Shared definitions for the 16-bit teaching CPU: default     |
// |               bus widths, instruction geometry, the halt opcode and the   |
// |               fetch-stage state encoding.                                 |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package cpu_pkg;

   // Default widths; modules expose these as overridable parameters.
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_OP_W    = 4;

   // One instruction occupies three consecutive words: op, a, b.
   localparam int INSTR_WORDS = 3;

   // Opcode that stops fetch when the halt feature is compiled in.
   localparam logic [3:0] OP_HALT = 4'hF;

   // Fetch-stage states. HALTED is only reachable when the halt feature
   // is compiled in.
   typedef enum logic [2:0] {
      RD_OP  = 3'd0,
      RD_A   = 3'd1,
      RD_B   = 3'd2,
      LAST   = 3'd3,
      VALID  = 3'd4,
      HALTED = 3'd5
   } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instr_fetch                                                 |
// | Description : Fetch stage ahead of the ALU datapath. Reads op, a and b    |
// |               from consecutive program-memory words starting at pc and    |
// |               offers them as one instruction over valid/ready. pc steps   |
// |               by three per accepted instruction; jump_en redirects.       |
// | Revision    : 1.0 - initial release                                       |
// |                                                                          |
// | Ports                                                                    |
// |   clk        in   clock, rising edge                                     |
// |   clr        in   asynchronous active-low reset                          |
// |   mem_addr   out  program-memory address                                 |
// |   mem_rd     out  read strobe (data returns one cycle later)             |
// |   mem_data   in   program-memory read data                               |
// |   op/a/b     out  instruction fields to the ALU stage                     |
// |   out_valid  out  op/a/b hold a complete instruction                     |
// |   out_ready  in   ALU stage accepts the instruction                      |
// |   pc         out  address of the instruction being fetched or held       |
// |   jump_en    in   redirect request (wins over everything but reset)      |
// |   jump_addr  in   redirect target                                        |
// |   halted     out  fetch stopped on a halt opcode                         |
// |                                                                          |
// | Build option                                                             |
// |   INSTR_FETCH_HALT_OP_EN : when defined, an OP_HALT opcode parks the      |
// |   stage in HALTED until reset or jump. When undefined, OP_HALT is an     |
// |   ordinary opcode and halted is tied low.                                |
// +--------------------------------------------------------------------------+
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int OP_W   = DEF_OP_W
) (
   input  logic              clk,
   input  logic              clr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] pc,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              halted
);

   fetch_state_t      r_state;
   fetch_state_t      w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [OP_W-1:0]   r_op;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;

   assign pc = r_pc;
   assign op = r_op;
   assign a  = r_a;
   assign b  = r_b;

   // State register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= RD_OP;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and outputs. Each RD_* state issues one read; the word
   // returned for it is captured one state later, so LAST only collects b.
   always_comb begin
      w_next_state = r_state;
      mem_rd       = 1'b0;
      mem_addr     = r_pc;
      out_valid    = 1'b0;
      halted       = 1'b0;

      case (r_state)
         RD_OP: begin
            mem_rd       = 1'b1;
            w_next_state = RD_A;
         end
         RD_A: begin
            mem_rd       = 1'b1;
            mem_addr     = r_pc + ADDR_W'(1);
            w_next_state = RD_B;
         end
         RD_B: begin
            mem_rd       = 1'b1;
            mem_addr     = r_pc + ADDR_W'(2);
            w_next_state = LAST;
         end
         LAST: begin
`ifdef INSTR_FETCH_HALT_OP_EN
            // op was captured on the RD_A -> RD_B edge, so it is stable here.
            if (r_op == OP_W'(OP_HALT)) begin
               w_next_state = HALTED;
            end else begin
               w_next_state = VALID;
            end
`else
            w_next_state = VALID;
`endif
         end
         VALID: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next_state = RD_OP;
            end
         end
`ifdef INSTR_FETCH_HALT_OP_EN
         HALTED: begin
            halted = 1'b1;
         end
`endif
         default: begin
            w_next_state = RD_OP;
         end
      endcase

      // A redirect abandons any partial fetch and drops a held instruction,
      // even one being accepted in the same cycle.
      if (jump_en) begin
         w_next_state = RD_OP;
      end
   end

   // pc and instruction field registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_pc <= '0;
         r_op <= '0;
         r_a  <= '0;
         r_b  <= '0;
      end else if (jump_en) begin
         r_pc <= jump_addr;
      end else begin
         case (r_state)
            RD_A:    r_op <= mem_data[OP_W-1:0];
            RD_B:    r_a  <= mem_data;
            LAST:    r_b  <= mem_data;
            VALID: begin
               if (out_ready) begin
                  r_pc <= r_pc + ADDR_W'(INSTR_WORDS);
               end
            end
            default: ;
         endcase
      end
   end

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_instr_fetch                                              |
// | Description : Self-checking bench for instr_fetch with a synchronous      |
// |               one-cycle-latency program memory model.                     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        clr;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] mem_data;
   logic [3:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  pc;
   logic        jump_en;
   logic [7:0]  jump_addr;
   logic        halted;

   logic [15:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] w2;
      logic [3:0]  eop;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [7:0]  epc_next;
   } vec_t;

   vec_t vecs [4];

   instr_fetch dut (
      .clk       (clk),
      .clr       (clr),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pc        (pc),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   // Program memory: address sampled at the edge, data valid next cycle.
   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_jump(input logic [7:0] target);
      jump_en   = 1'b1;
      jump_addr = target;
      @(negedge clk);
      jump_en   = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int max, output int n);
      n = 0;
      while (!out_valid && n < max) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid_seen"}, 32'(out_valid), 32'd1);
   endtask

   initial begin
      int n;
      logic [7:0] ad;
      bit vseen;

      vecs[0] = '{8'd254, 16'h0002, 16'h0007, 16'h0009, 4'h2, 16'h0007, 16'h0009, 8'd1};
      vecs[1] = '{8'h10,  16'hABC5, 16'hFFFF, 16'h0000, 4'h5, 16'hFFFF, 16'h0000, 8'h13};
      vecs[2] = '{8'h80,  16'h000E, 16'h1234, 16'h8000, 4'hE, 16'h1234, 16'h8000, 8'h83};
      vecs[3] = '{8'd253, 16'h0001, 16'h0002, 16'h0003, 4'h1, 16'h0002, 16'h0003, 8'd0};

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0] = 16'h0001; mem[1] = 16'h0005; mem[2] = 16'h0003;
      mem[3] = 16'h0007; mem[4] = 16'h1111; mem[5] = 16'h2222;

      clr = 1'b0; out_ready = 1'b0; jump_en = 1'b0; jump_addr = 8'h00; mem_data = 16'h0000;
      repeat (2) @(negedge clk);

      // Reset values
      check("rst_pc",       32'(pc),        32'd0);
      check("rst_op",       32'(op),        32'd0);
      check("rst_a",        32'(a),         32'd0);
      check("rst_b",        32'(b),         32'd0);
      check("rst_valid",    32'(out_valid), 32'd0);
      check("rst_halted",   32'(halted),    32'd0);
      check("rst_mem_rd",   32'(mem_rd),    32'd1);
      check("rst_mem_addr", 32'(mem_addr),  32'd0);

      // First instruction after reset release, out_ready held high
      out_ready = 1'b1;
      clr       = 1'b1;
      @(negedge clk);
      check("e1_addr",  32'(mem_addr),  32'd1);
      check("e1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("e2_addr",  32'(mem_addr),  32'd2);
      @(negedge clk);
      check("e3_mem_rd", 32'(mem_rd),    32'd0);
      check("e3_valid",  32'(out_valid), 32'd0);
      @(negedge clk);
      check("e4_valid", 32'(out_valid), 32'd1);
      check("i0_op",    32'(op),        32'd1);
      check("i0_a",     32'(a),         32'd5);
      check("i0_b",     32'(b),         32'd3);
      check("i0_pc",    32'(pc),        32'd0);
      @(negedge clk);
      check("acc_pc",    32'(pc),        32'd3);
      check("acc_valid", 32'(out_valid), 32'd0);
      check("i1_addr0",  32'(mem_addr),  32'd3);
      check("i1_rd0",    32'(mem_rd),    32'd1);
      @(negedge clk);
      check("i1_addr1",  32'(mem_addr),  32'd4);
      @(negedge clk);
      check("i1_addr2",  32'(mem_addr),  32'd5);
      out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Stall: instruction held, memory changed underneath
      check("i1_op", 32'(op), 32'd7);
      check("i1_a",  32'(a),  32'h1111);
      check("i1_b",  32'(b),  32'h2222);
      mem[3] = 16'hDEAD; mem[4] = 16'hBEEF; mem[5] = 16'hCAFE;
      repeat (10) begin
         @(negedge clk);
         check("stall_valid",  32'(out_valid), 32'd1);
         check("stall_mem_rd", 32'(mem_rd),    32'd0);
         check("stall_op",     32'(op),        32'd7);
         check("stall_a",      32'(a),         32'h1111);
         check("stall_b",      32'(b),         32'h2222);
         check("stall_pc",     32'(pc),        32'd3);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_acc_pc",    32'(pc),        32'd6);
      check("stall_acc_valid", 32'(out_valid), 32'd0);

      // Jump while in RD_B: partial fetch from 6 is abandoned
      out_ready = 1'b0;
      mem[6] = 16'h0003; mem[7] = 16'hAAAA; mem[8] = 16'hBBBB;
      mem[8'h20] = 16'h0004; mem[8'h21] = 16'h0100; mem[8'h22] = 16'h0200;
      repeat (2) @(negedge clk);
      check("rdb_addr", 32'(mem_addr), 32'd8);
      do_jump(8'h20);
      check("jmp_addr",   32'(mem_addr),  32'h20);
      check("jmp_pc",     32'(pc),        32'h20);
      check("jmp_valid",  32'(out_valid), 32'd0);
      check("jmp_mem_rd", 32'(mem_rd),    32'd1);
      wait_valid("jmp", 8, n);
      check("jmp_latency", 32'(n),  32'd4);
      check("jmp_op",      32'(op), 32'd4);
      check("jmp_a",       32'(a),  32'h0100);
      check("jmp_b",       32'(b),  32'h0200);
      check("jmp_ipc",     32'(pc), 32'h20);

      // Jump in VALID with out_ready high: jump wins, no transfer
      out_ready = 1'b1;
      do_jump(8'h40);
      out_ready = 1'b0;
      check("jv_valid", 32'(out_valid), 32'd0);
      check("jv_pc",    32'(pc),        32'h40);
      check("jv_addr",  32'(mem_addr),  32'h40);

      // Table-driven instructions, including address wrap
      for (int i = 0; i < 4; i++) begin
         ad = vecs[i].addr;
         mem[ad] = vecs[i].w0; ad = ad + 8'd1;
         mem[ad] = vecs[i].w1; ad = ad + 8'd1;
         mem[ad] = vecs[i].w2;
         out_ready = 1'b0;
         do_jump(vecs[i].addr);
         wait_valid("vec", 8, n);
         check("vec_latency", 32'(n),  32'd4);
         check("vec_op",      32'(op), 32'(vecs[i].eop));
         check("vec_a",       32'(a),  32'(vecs[i].ea));
         check("vec_b",       32'(b),  32'(vecs[i].eb));
         check("vec_pc",      32'(pc), 32'(vecs[i].addr));
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check("vec_pc_next", 32'(pc),        32'(vecs[i].epc_next));
         check("vec_valid_0", 32'(out_valid), 32'd0);
      end

      // Halt opcode
      mem[8'h30] = 16'h000F; mem[8'h31] = 16'h0011; mem[8'h32] = 16'h0022;
      mem[3] = 16'h0008; mem[4] = 16'h0033; mem[5] = 16'h0044;
      out_ready = 1'b0;
      do_jump(8'h30);
`ifdef INSTR_FETCH_HALT_OP_EN
      vseen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) vseen = 1'b1;
      end
      check("halt_no_valid", 32'(vseen),  32'd0);
      check("halt_flag",     32'(halted), 32'd1);
      check("halt_pc",       32'(pc),     32'h30);
      check("halt_mem_rd",   32'(mem_rd), 32'd0);
      do_jump(8'd3);
      check("unhalt_flag", 32'(halted), 32'd0);
      wait_valid("unhalt", 8, n);
      check("unhalt_op", 32'(op), 32'd8);
      check("unhalt_a",  32'(a),  32'h0033);
      check("unhalt_b",  32'(b),  32'h0044);
      check("unhalt_pc", 32'(pc), 32'd3);
`else
      vseen = 1'b0;
      wait_valid("hop", 8, n);
      check("hop_op",     32'(op),     32'hF);
      check("hop_a",      32'(a),      32'h0011);
      check("hop_b",      32'(b),      32'h0022);
      check("hop_halted", 32'(halted), 32'd0);
`endif

      // Reset mid-fetch
      mem[0] = 16'h0006; mem[1] = 16'h0066; mem[2] = 16'h0666;
      do_jump(8'h50);
      @(negedge clk);
      #2 clr = 1'b0;
      #1;
      check("mrst_pc",    32'(pc),        32'd0);
      check("mrst_op",    32'(op),        32'd0);
      check("mrst_a",     32'(a),         32'd0);
      check("mrst_b",     32'(b),         32'd0);
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_addr",  32'(mem_addr),  32'd0);
      @(negedge clk);
      clr = 1'b1;
      wait_valid("mrst", 8, n);
      check("mrst_latency", 32'(n),  32'd4);
      check("mrst_op2",     32'(op), 32'd6);
      check("mrst_a2",      32'(a),  32'h0066);
      check("mrst_b2",      32'(b),  32'h0666);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the ALU datapath in the 16-bit teaching CPU.
- Reads three consecutive words (op, a, b) from synchronous program memory starting at pc. Presents them as one instruction to the ALU stage over a valid/ready handshake.
- Advances pc by 3 per accepted instruction. A downstream jump redirects fetch.

Parameters:
- ADDR_W, 8: program-memory address width; pc wraps modulo 2^ADDR_W.
- DATA_W, 16: memory word and operand width.
- OP_W, 4: opcode width; op is taken from mem_data[OP_W-1:0], upper bits ignored.

Ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  program-memory address (combinational from state/pc).
- mem_rd  out  1  read strobe; memory samples mem_addr at the edge and returns mem_data the following cycle.
- mem_data  in  DATA_W  read data, one-cycle latency.
- op  out  OP_W  opcode to ALU.
- a  out  DATA_W  operand a.
- b  out  DATA_W  operand b.
- out_valid  out  1  op/a/b hold a complete instruction.
- out_ready  in  1  ALU stage accepts the instruction.
- pc  out  ADDR_W  address of the instruction being fetched or held.
- jump_en  in  1  redirect request.
- jump_addr  in  ADDR_W  redirect target.
- halted  out  1  see Optional Feature.

Behaviour:
- Reset (clr=0, asynchronous): pc=0, op=0, a=0, b=0, out_valid=0, halted=0, state=RD_OP.
- States:
  - RD_OP: mem_rd=1, mem_addr=pc. Next state RD_A.
  - RD_A: mem_rd=1, mem_addr=pc+1. Latch op. Next state RD_B.
  - RD_B: mem_rd=1, mem_addr=pc+2. Latch a. Next state LAST.
  - LAST: mem_rd=0. Latch b. Next state VALID.
  - VALID: out_valid=1, mem_rd=0. On out_valid&&out_ready: pc<=pc+3, next state RD_OP.
- Latency: out_valid rises after the 4th rising edge following reset release or redirect. Best-case throughput is 1 instruction per 5 cycles.
- Address arithmetic is modulo 2^ADDR_W. With pc=254 the reads are 254, 255, 0; after acceptance pc becomes 1.
- op/a/b are stable while out_valid=1 and out_ready=0, held indefinitely with no re-read.
- mem_addr is don't-care when mem_rd=0, but must be driven to pc.
- jump_en=1 in any state at an edge: pc<=jump_addr, state<=RD_OP, out_valid<=0.
  - A held instruction is dropped, even if out_ready=1 in the same cycle; jump wins and no transfer occurs.
  - A partial fetch is abandoned.
- Reset asserted mid-fetch or mid-handshake returns immediately to reset values; no partial instruction survives.
- out_valid never rises without all three words latched from the same pc.

Optional Feature:
- Macro: INSTR_FETCH_HALT_OP_EN.
- Defined:
  - In LAST, if the latched op==OP_HALT (4'hF), go to HALTED instead of VALID.
  - HALTED: halted=1, out_valid=0, mem_rd=0, pc frozen.
  - Exit HALTED only via reset or jump_en. Jump clears halted and goes to RD_OP.
- Undefined: 4'hF is an ordinary opcode passed to the ALU; halted is tied 0; the HALTED state does not exist.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W/DATA_W/OP_W defaults;
  - INSTR_WORDS=3 (pc step);
  - OP_HALT=4'hF;
  - fetch state enumeration (RD_OP, RD_A, RD_B, LAST, VALID, HALTED).
- No sub-module is warranted: a single FSM plus pc and operand registers.

Test Plan:
- Memory [0]=0x0001, [1]=0x0005, [2]=0x0003, out_ready=1 after reset -> out_valid after 4th edge with op=1, a=5, b=3; next mem_addr sequence 3, 4, 5; pc=3.
- out_ready=0 for 10 cycles while valid, memory contents changed meanwhile -> op/a/b unchanged, mem_rd=0 throughout; acceptance on first ready cycle moves pc 0->3.
- jump_en with jump_addr=0x20 during RD_B -> next mem_addr=0x20; the abandoned instruction is never presented; instruction from 0x20..0x22 is presented.
- jump_en with out_ready=1 in VALID -> no transfer counted, pc=jump_addr, out_valid=0 next cycle.
- pc=254 via jump, memory [254]=2, [255]=0x7, [0]=0x9 -> op=2, a=7, b=9; after accept pc=1.
- With INSTR_FETCH_HALT_OP_EN: [0]=0x000F -> halted=1, out_valid never rises; jump to 3 -> halted=0 and fetch resumes. Without the macro: same memory -> op=0xF presented, halted=0.
